mio_bus_initiator: RTL
======================

MIO_BUS_INITIATOR -- requirements
Module: mio_bus_initiator

Interface
REQ-001 SHALL have parameter RAM_WAIT, default 1, extra bus cycles for region 0x0 (RAM) reads.
REQ-002 SHALL have parameter PERIPH_WAIT, default 0, extra bus cycles for regions 0xE/0xF reads.
REQ-003 SHALL use one clock and an asynchronous, active-low reset; all ports are listed below.
REQ-004 clk  in  1  sole clock, rising edge.
REQ-005 rst_n  in  1  asynchronous active-low reset.
REQ-006 req_valid / req_ready  in / out  1 / 1  core request handshake.
REQ-007 req_we  in  1  1 = write, 0 = read.
REQ-008 req_addr / req_wdata  in  32 / 32  request address and write data.
REQ-009 resp_valid / resp_ready  out / in  1 / 1  response handshake.
REQ-010 resp_rdata / resp_err  out  32 / 1  read data and error flag.
REQ-011 mem_w  out  1  bus write strobe.
REQ-012 addr_bus / Cpu_data2bus  out  32 / 32  bus address and write data.
REQ-013 Cpu_data4bus  in  32  bus read data.

Function
REQ-014 SHALL be an FSM with states IDLE, ACCESS, WAIT, RESP.
REQ-015 req_ready SHALL be 1 only in IDLE; a request is accepted on the clk edge where req_valid && req_ready.
REQ-016 At acceptance SHALL latch req_we/addr/wdata and decode region addr[31:28].
- 0x0 -> W = RAM_WAIT.
- 0xE, 0xF -> W = PERIPH_WAIT.
- others -> unmapped.
- Writes always use W = 0.
REQ-017 Mapped: IDLE -> ACCESS. ACCESS -> WAIT if W>0, else RESP. WAIT counts W cycles, then -> RESP.
REQ-018 Unmapped: IDLE -> RESP directly, no bus cycle, resp_err = 1, resp_rdata = 0.
REQ-019 addr_bus and Cpu_data2bus SHALL hold the latched values throughout ACCESS and WAIT; otherwise 0.
REQ-020 mem_w SHALL be 1 for exactly the ACCESS cycle of a write; never asserted on reads or in other states.
REQ-021 Reads SHALL capture Cpu_data4bus on the last ACCESS/WAIT cycle into resp_rdata.
REQ-022 Writes SHALL return resp_rdata = 0, resp_err = 0.
REQ-023 Latency: for acceptance at edge T, resp_valid SHALL rise at T+2+W (mapped) or T+1 (unmapped).
REQ-024 resp_valid, resp_rdata and resp_err SHALL be held stable in RESP until resp_ready.
- RESP -> IDLE on resp_ready.
- resp_ready already high when RESP is entered completes in that one cycle.
REQ-025 The wait counter SHALL be wide enough for max(RAM_WAIT, PERIPH_WAIT); W = 0 SHALL skip WAIT entirely.
REQ-026 Inputs SHALL be ignored outside IDLE; there is no request queuing.

Reset
REQ-027 rst_n low SHALL immediately force IDLE, with these outputs:
- req_ready = 1 after release.
- resp_valid = 0, resp_rdata = 0, resp_err = 0.
- mem_w = 0, addr_bus = 0, Cpu_data2bus = 0.
- counter cleared.
REQ-028 Reset mid-access SHALL abort the transaction silently; no response is issued after release.

Configuration
REQ-029 With MIO_ALIGN_CHECK_EN defined, a request with req_addr[1:0] != 0 SHALL be handled as unmapped (REQ-018).
REQ-030 Without MIO_ALIGN_CHECK_EN, req_addr[1:0] SHALL be ignored and the access SHALL proceed normally.

Structure
REQ-031 Package mio_pkg SHALL hold the region codes (4'h0, 4'hE, 4'hF) and the FSM state encoding.
REQ-032 Sub-module mio_region_decode (combinational: addr -> mapped flag, W) SHALL be instantiated once.

Verification
REQ-033 Read 0x00000010 with RAM_WAIT=1, Cpu_data4bus = 0xDEADBEEF on the second bus cycle -> resp_valid at T+3, resp_rdata = 0xDEADBEEF, mem_w never high.
REQ-034 Write 0xE0000000 with data 0x12345678 -> mem_w high exactly one cycle with addr_bus = 0xE0000000, Cpu_data2bus = 0x12345678; resp at T+2, resp_err = 0.
REQ-035 Read 0x50000000 -> no bus activity, resp_valid at T+1, resp_err = 1, resp_rdata = 0.
REQ-036 Hold resp_ready = 0 for 5 cycles after response -> resp_valid and data stable, req_ready = 0 throughout; back-to-back request accepted the cycle after the handshake.
REQ-037 Assert rst_n low during WAIT -> all outputs 0 immediately, no response after release.
REQ-038 With MIO_ALIGN_CHECK_EN, read 0xF0000006 -> resp_err = 1, no bus cycle; without it -> normal read, addr_bus = 0xF0000006.

Source files
------------

// File: rtl/mio_pkg.sv
// Shared definitions for the MIO bus initiator: region codes, FSM state
// encoding and the wait-counter sizing helper.
package mio_pkg;

   localparam logic [3:0] REGION_RAM      = 4'h0;
   localparam logic [3:0] REGION_PERIPH_E = 4'hE;
   localparam logic [3:0] REGION_PERIPH_F = 4'hF;

   typedef enum logic [1:0] {
      IDLE   = 2'd0,
      ACCESS = 2'd1,
      WAIT   = 2'd2,
      RESP   = 2'd3
   } state_t;

   // Smallest width (at least 1) that can hold max_wait.
   function automatic int cnt_width(input int max_wait);
      int w;
      w = 1;
      while ((1 << w) <= max_wait) w++;
      return w;
   endfunction

endpackage

// File: rtl/mio_bus_initiator_if.sv
// Core request/response handshake plus the memory-mapped bus signals.
// The master modport is the initiator's view; slave is the core/bus side.
interface mio_bus_initiator_if;

   logic        req_valid;
   logic        req_ready;
   logic        req_we;
   logic [31:0] req_addr;
   logic [31:0] req_wdata;
   logic        resp_valid;
   logic        resp_ready;
   logic [31:0] resp_rdata;
   logic        resp_err;
   logic        mem_w;
   logic [31:0] addr_bus;
   logic [31:0] Cpu_data2bus;
   logic [31:0] Cpu_data4bus;

   modport master (
      input  req_valid, req_we, req_addr, req_wdata, resp_ready, Cpu_data4bus,
      output req_ready, resp_valid, resp_rdata, resp_err, mem_w, addr_bus, Cpu_data2bus
   );

   modport slave (
      output req_valid, req_we, req_addr, req_wdata, resp_ready, Cpu_data4bus,
      input  req_ready, resp_valid, resp_rdata, resp_err, mem_w, addr_bus, Cpu_data2bus
   );

endinterface

// File: rtl/mio_region_decode.sv
// Combinational address decode: region -> mapped flag and wait cycles.
// Define MIO_ALIGN_CHECK_EN to treat non-word-aligned addresses as unmapped.
module mio_region_decode
   import mio_pkg::*;
#(
   parameter int RAM_WAIT    = 1,
   parameter int PERIPH_WAIT = 0,
   parameter int CNT_W       = 1
) (
   input  logic [31:0]      addr,
   input  logic             we,
   output logic             mapped,
   output logic [CNT_W-1:0] wait_cycles
);

   logic             region_hit;
   logic [CNT_W-1:0] region_wait;
   logic             unused_addr_bits;

   always_comb begin
      region_hit  = 1'b0;
      region_wait = '0;
      case (addr[31:28])
         REGION_RAM: begin
            region_hit  = 1'b1;
            region_wait = CNT_W'(RAM_WAIT);
         end
         REGION_PERIPH_E, REGION_PERIPH_F: begin
            region_hit  = 1'b1;
            region_wait = CNT_W'(PERIPH_WAIT);
         end
         default: ;
      endcase
   end

`ifdef MIO_ALIGN_CHECK_EN
   assign mapped           = region_hit && (addr[1:0] == 2'b00);
   assign unused_addr_bits = ^addr[27:2];
`else
   assign mapped           = region_hit;
   assign unused_addr_bits = ^addr[27:0];
`endif

   // Writes never stall, whatever the region's read latency.
   assign wait_cycles = we ? '0 : region_wait;

endmodule

// File: rtl/mio_bus_initiator.sv
// Single-outstanding bus initiator bridging a valid/ready core port to the MIO bus.
// Honours MIO_ALIGN_CHECK_EN through mio_region_decode.
module mio_bus_initiator
   import mio_pkg::*;
#(
   parameter int RAM_WAIT    = 1,
   parameter int PERIPH_WAIT = 0
) (
   input  logic                 clk,
   input  logic                 rst_n,
   mio_bus_initiator_if.master  bus
);

   localparam int MAX_WAIT = (RAM_WAIT > PERIPH_WAIT) ? RAM_WAIT : PERIPH_WAIT;
   localparam int CNT_W    = cnt_width(MAX_WAIT);

   state_t           state, state_next;
   logic [CNT_W-1:0] cnt, cnt_next;
   logic             we_q;
   logic [31:0]      addr_q;
   logic [31:0]      wdata_q;
   logic [31:0]      rdata_q;
   logic             err_q;
   logic             dec_mapped;
   logic [CNT_W-1:0] dec_wait;
   logic             accept;
   logic             bus_last;
   logic             in_bus;

   mio_region_decode #(
      .RAM_WAIT    (RAM_WAIT),
      .PERIPH_WAIT (PERIPH_WAIT),
      .CNT_W       (CNT_W)
   ) u_decode (
      .addr        (bus.req_addr),
      .we          (bus.req_we),
      .mapped      (dec_mapped),
      .wait_cycles (dec_wait)
   );

   assign accept   = bus.req_valid && (state == IDLE);
   assign bus_last = ((state == ACCESS) && (cnt == '0)) ||
                     ((state == WAIT)   && (cnt == CNT_W'(1)));

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state <= IDLE;
         cnt   <= '0;
      end else begin
         state <= state_next;
         cnt   <= cnt_next;
      end
   end

   // WAIT is entered holding W and leaves once the counter reaches 1.
   always_comb begin
      state_next = state;
      cnt_next   = cnt;
      case (state)
         IDLE: begin
            if (bus.req_valid) begin
               if (dec_mapped) begin
                  state_next = ACCESS;
                  cnt_next   = dec_wait;
               end else begin
                  state_next = RESP;
               end
            end
         end
         ACCESS: state_next = (cnt == '0) ? RESP : WAIT;
         WAIT: begin
            if (cnt == CNT_W'(1)) begin
               state_next = RESP;
               cnt_next   = '0;
            end else begin
               cnt_next = cnt - CNT_W'(1);
            end
         end
         RESP: begin
            if (bus.resp_ready) state_next = IDLE;
         end
         default: state_next = IDLE;
      endcase
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         we_q    <= 1'b0;
         addr_q  <= '0;
         wdata_q <= '0;
         rdata_q <= '0;
         err_q   <= 1'b0;
      end else if (accept) begin
         we_q    <= bus.req_we;
         addr_q  <= bus.req_addr;
         wdata_q <= bus.req_wdata;
         rdata_q <= '0;
         err_q   <= !dec_mapped;
      end else if (bus_last && !we_q) begin
         rdata_q <= bus.Cpu_data4bus;
      end
   end

   assign in_bus           = (state == ACCESS) || (state == WAIT);
   assign bus.req_ready    = (state == IDLE);
   assign bus.addr_bus     = in_bus ? addr_q  : '0;
   assign bus.Cpu_data2bus = in_bus ? wdata_q : '0;
   assign bus.mem_w        = (state == ACCESS) && we_q;
   assign bus.resp_valid   = (state == RESP);
   assign bus.resp_rdata   = bus.resp_valid ? rdata_q : '0;
   assign bus.resp_err     = bus.resp_valid && err_q;

endmodule
